// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the axi_to_mem write path: burst/response encodings,
// FSM state type and the per-beat AXI address stepping function.
package axi_to_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_RESP
    } state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Computed at 64 bits; callers truncate to their address width, which gives
    // the modulo-2^AddrWidth wrap for free. Illegal WRAP and reserved fall back to INCR.
    function automatic logic [63:0] axi_beat_next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] step_bytes;
        logic [63:0] wrap_bytes;
        logic [63:0] aligned;
        logic [63:0] incr;
        logic [63:0] base;
        step_bytes = 64'd1 << size;
        wrap_bytes = ({56'd0, len} + 64'd1) << size;
        aligned    = addr & ~(step_bytes - 64'd1);
        incr       = aligned + step_bytes;
        base       = aligned & ~(wrap_bytes - 64'd1);
        if (burst == BURST_FIXED) begin
            return addr;
        end
        if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
            if ((incr & (wrap_bytes - 64'd1)) == 64'd0) begin
                return base;
            end
        end
        return incr;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat address generator: loads the AXI start address with the burst shape
// and steps to the next beat address on each completed beat.
module axi_burst_addr_gen
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic [2:0]           size_i,
    input  logic [7:0]           len_i,
    input  logic [1:0]           burst_i,
    input  logic                 step_i,
    output logic [AddrWidth-1:0] addr_o
);

    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] next_addr;
    logic [2:0]           size_q;
    logic [7:0]           len_q;
    logic [1:0]           burst_q;

    assign next_addr = AddrWidth'(axi_beat_next_addr(64'(addr_q), size_q, len_q, burst_q));

    // The first beat uses the unmodified start address; alignment happens on the first step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
        end else if (load_i) begin
            addr_q  <= start_addr_i;
            size_q  <= size_i;
            len_q   <= len_i;
            burst_q <= burst_i;
        end else if (step_i) begin
            addr_q  <= next_addr;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/axi_w_burst_mem_req_gen.sv
// AXI write-path stage: turns one AW burst plus its W beats into memory write
// requests and returns the B response once the last beat is granted.
module axi_w_burst_mem_req_gen
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic [2:0]           aw_size_i,
    input  logic [1:0]           aw_burst_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 w_last_i,
    input  logic [UserWidth-1:0] w_user_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [StrbWidth-1:0] mem_strb_o,
    output logic [UserWidth-1:0] mem_user_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o
);

    state_e             state_q, state_d;
    logic [IdWidth-1:0] id_q;
    logic [7:0]         len_q;
    logic [7:0]         beat_cnt_q;
    logic               err_q;
    logic               aw_load;
    logic               beat_done;
    logic               last_beat;
    logic               aw_err;

    assign last_beat = (beat_cnt_q == len_q);
    assign aw_err    = (aw_burst_i == 2'd3) ||
                       ((aw_burst_i == BURST_WRAP) && !wrap_len_ok(aw_len_i));

    // Request only follows w_valid_i so the memory side never sees a gnt->req loop.
    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        mem_req_o  = 1'b0;
        b_valid_o  = 1'b0;
        aw_load    = 1'b0;
        beat_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                aw_ready_o = !flush_i;
                if (aw_valid_i && !flush_i) begin
                    aw_load = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                mem_req_o = w_valid_i && !flush_i;
                w_ready_o = mem_gnt_i && !flush_i;
                beat_done = w_valid_i && mem_gnt_i && !flush_i;
                if (beat_done && last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                b_valid_o = !flush_i;
                if (b_ready_i && !flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst length decides the end of the burst; a misplaced w_last_i only marks the error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q       <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (flush_i) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (aw_load) begin
            id_q       <= aw_id_i;
            len_q      <= aw_len_i;
            beat_cnt_q <= '0;
            err_q      <= aw_err;
        end else if (beat_done) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (w_last_i != last_beat) begin
                err_q <= 1'b1;
            end
        end
    end

    axi_burst_addr_gen #(
        .AddrWidth (AddrWidth)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (aw_load),
        .start_addr_i (aw_addr_i),
        .size_i       (aw_size_i),
        .len_i        (aw_len_i),
        .burst_i      (aw_burst_i),
        .step_i       (beat_done),
        .addr_o       (mem_addr_o)
    );

    assign mem_wdata_o = w_data_i;
    assign mem_strb_o  = w_strb_i;
    assign mem_user_o  = w_user_i;
    assign b_id_o      = id_q;
    assign b_resp_o    = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_w_burst_mem_req_gen.sv
// Directed scoreboard bench for axi_w_burst_mem_req_gen: expected memory
// requests and B responses are queued at stimulus time and popped on output.
module tb_axi_w_burst_mem_req_gen;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          aw_valid;
    logic          aw_ready;
    logic [IW-1:0] aw_id;
    logic [AW-1:0] aw_addr;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size;
    logic [1:0]    aw_burst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          w_last;
    logic [UW-1:0] w_user;
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_strb;
    logic [UW-1:0] mem_user;
    logic          b_valid;
    logic          b_ready;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
    } mem_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    mem_exp_t mem_q[$];
    b_exp_t   b_q[$];
    int       checks = 0;
    int       errors = 0;
    logic     gnt_phase = 1'b0;

    axi_w_burst_mem_req_gen #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW),
        .UserWidth (UW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .aw_id_i     (aw_id),
        .aw_addr_i   (aw_addr),
        .aw_len_i    (aw_len),
        .aw_size_i   (aw_size),
        .aw_burst_i  (aw_burst),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_data_i    (w_data),
        .w_strb_i    (w_strb),
        .w_last_i    (w_last),
        .w_user_i    (w_user),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_strb_o  (mem_strb),
        .mem_user_o  (mem_user),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [DW-1:0] beat_data(input int tag, input int i);
        return {32'hA5A5_0000 + 32'(tag), 32'h1000_0000 + 32'(i)};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int i);
        return 8'hFF >> (i % 4);
    endfunction

    // Address reference written from the burst definition: offset within the wrap window.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input int size,
                                                 input int len, input logic [1:0] burst, input int i);
        longint unsigned bytes, aligned, wsize, base;
        bytes   = 64'd1 << size;
        aligned = 64'(start) & ~(bytes - 1);
        if (i == 0 || burst == 2'd0) return start;
        if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            wsize = 64'(len + 1) * bytes;
            base  = (aligned / wsize) * wsize;
            return AW'(base + ((aligned - base + 64'(i) * bytes) % wsize));
        end
        return AW'(aligned + 64'(i) * bytes);
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input int len, input int size, input logic [1:0] burst,
                              input logic [1:0] resp);
        mem_exp_t m;
        b_exp_t   b;
        for (int i = 0; i <= len; i++) begin
            m.addr = model_addr(addr, size, len, burst, i);
            m.data = beat_data(tag, i);
            m.strb = beat_strb(i);
            m.user = UW'(i % 2);
            mem_q.push_back(m);
        end
        b.id   = id;
        b.resp = resp;
        b_q.push_back(b);
    endtask

    task automatic apply_stimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                  input int len, input int size, input logic [1:0] burst);
        aw_valid = 1'b1;
        aw_id    = id;
        aw_addr  = addr;
        aw_len   = 8'(len);
        aw_size  = 3'(size);
        aw_burst = burst;
        #1;
        check_output("aw_ready_idle", 64'(aw_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        check_output("aw_ready_burst", 64'(aw_ready), 64'd0);
    endtask

    task automatic run_beats(input int tag, input int first, input int n,
                             input int last_idx, input bit toggle);
        mem_exp_t e;
        bit       done;
        for (int i = first; i < first + n; i++) begin
            w_valid = 1'b1;
            w_data  = beat_data(tag, i);
            w_strb  = beat_strb(i);
            w_last  = (i == last_idx);
            w_user  = UW'(i % 2);
            done    = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                gnt_phase = ~gnt_phase;
                mem_gnt   = toggle ? gnt_phase : 1'b1;
                #1;
                check_output("mem_req", 64'(mem_req), 64'd1);
                check_output("w_ready_gnt", 64'(w_ready), 64'(mem_gnt));
                if (mem_q.size() == 0) begin
                    check_output("mem_q_empty", 64'd1, 64'd0);
                end else begin
                    e = mem_q[0];
                    check_output("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check_output("mem_wdata", mem_wdata, e.data);
                    check_output("mem_strb", 64'(mem_strb), 64'(e.strb));
                    check_output("mem_user", 64'(mem_user), 64'(e.user));
                    if (mem_gnt) void'(mem_q.pop_front());
                end
                done = mem_gnt;
                @(posedge clk); #1;
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        mem_gnt = 1'b0;
    endtask

    task automatic check_b(input int hold);
        b_exp_t e;
        if (b_q.size() == 0) begin
            check_output("b_q_empty", 64'd1, 64'd0);
            return;
        end
        e = b_q.pop_front();
        for (int k = 0; k <= hold; k++) begin
            b_ready = (k == hold);
            #1;
            check_output("b_valid", 64'(b_valid), 64'd1);
            check_output("b_id", 64'(b_id), 64'(e.id));
            check_output("b_resp", 64'(b_resp), 64'(e.resp));
            check_output("aw_ready_resp", 64'(aw_ready), 64'd0);
            @(posedge clk); #1;
        end
        b_ready = 1'b0;
        #1;
        check_output("b_valid_after", 64'(b_valid), 64'd0);
        check_output("aw_ready_after_b", 64'(aw_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; aw_valid = 1'b0; aw_id = '0; aw_addr = '0;
        aw_len = '0; aw_size = '0; aw_burst = '0; w_valid = 1'b0; w_data = '0;
        w_strb = '0; w_last = 1'b0; w_user = '0; mem_gnt = 1'b0; b_ready = 1'b0;
        #12;
        check_output("rst_aw_ready", 64'(aw_ready), 64'd1);
        check_output("rst_w_ready", 64'(w_ready), 64'd0);
        check_output("rst_mem_req", 64'(mem_req), 64'd0);
        check_output("rst_b_valid", 64'(b_valid), 64'd0);
        check_output("rst_b_id", 64'(b_id), 64'd0);
        check_output("rst_b_resp", 64'(b_resp), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] INCR burst");
        push_burst(1, 4'h5, 32'h1000, 3, 3, 2'd1, 2'd0);
        apply_stimulus(4'h5, 32'h1000, 3, 3, 2'd1);
        run_beats(1, 0, 4, 3, 1'b0);
        check_b(0);

        $display("[TB] WRAP burst");
        @(posedge clk); #1;
        push_burst(2, 4'h6, 32'h1018, 3, 3, 2'd2, 2'd0);
        apply_stimulus(4'h6, 32'h1018, 3, 3, 2'd2);
        run_beats(2, 0, 4, 3, 1'b0);
        check_b(0);

        $display("[TB] FIXED burst with stalls");
        push_burst(3, 4'h7, 32'h2004, 2, 2, 2'd0, 2'd0);
        apply_stimulus(4'h7, 32'h2004, 2, 2, 2'd0);
        gnt_phase = 1'b1;
        run_beats(3, 0, 3, 2, 1'b1);
        check_b(0);

        $display("[TB] early w_last");
        push_burst(4, 4'h9, 32'h3000, 3, 3, 2'd1, 2'd2);
        apply_stimulus(4'h9, 32'h3000, 3, 3, 2'd1);
        run_beats(4, 0, 4, 1, 1'b0);
        check_b(0);

        $display("[TB] WRAP with illegal length");
        push_burst(5, 4'h2, 32'h8008, 2, 3, 2'd2, 2'd2);
        apply_stimulus(4'h2, 32'h8008, 2, 3, 2'd2);
        run_beats(5, 0, 3, 2, 1'b0);
        check_b(0);

        $display("[TB] flush mid-burst");
        push_burst(6, 4'h3, 32'h4000, 7, 3, 2'd1, 2'd0);
        apply_stimulus(4'h3, 32'h4000, 7, 3, 2'd1);
        run_beats(6, 0, 2, 7, 1'b0);
        flush    = 1'b1;
        w_valid  = 1'b1;
        mem_gnt  = 1'b1;
        aw_valid = 1'b1;
        aw_id    = 4'hE;
        #1;
        check_output("flush_mem_req", 64'(mem_req), 64'd0);
        check_output("flush_w_ready", 64'(w_ready), 64'd0);
        check_output("flush_aw_ready", 64'(aw_ready), 64'd0);
        check_output("flush_b_valid", 64'(b_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        aw_valid = 1'b0;
        #1;
        check_output("post_flush_aw_ready", 64'(aw_ready), 64'd1);
        check_output("post_flush_mem_req", 64'(mem_req), 64'd0);
        check_output("post_flush_b_valid", 64'(b_valid), 64'd0);
        w_valid = 1'b0;
        mem_gnt = 1'b0;
        mem_q.delete();
        b_q.delete();
        @(posedge clk); #1;
        push_burst(7, 4'hA, 32'h5000, 1, 3, 2'd1, 2'd0);
        apply_stimulus(4'hA, 32'h5000, 1, 3, 2'd1);
        run_beats(7, 0, 2, 1, 1'b0);
        check_b(0);

        $display("[TB] B backpressure");
        push_burst(8, 4'hC, 32'h6000, 0, 3, 2'd1, 2'd0);
        apply_stimulus(4'hC, 32'h6000, 0, 3, 2'd1);
        run_beats(8, 0, 1, 0, 1'b0);
        push_burst(9, 4'hD, 32'h7000, 0, 3, 2'd1, 2'd0);
        aw_valid = 1'b1;
        aw_id    = 4'hD;
        aw_addr  = 32'h7000;
        aw_len   = 8'd0;
        aw_size  = 3'd3;
        aw_burst = 2'd1;
        check_b(5);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        check_output("aw_after_resp_accepted", 64'(aw_ready), 64'd0);
        run_beats(9, 0, 1, 0, 1'b0);
        check_b(0);

        check_output("mem_q_drained", 64'(mem_q.size()), 64'd0);
        check_output("b_q_drained", 64'(b_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
